// File: rtl/mmio_keys_queued.sv
// mmio_keys_queued: word-mapped CPC key matrix with a paced key-event FIFO.
// Define MMIO_KEYS_IRQ_EN to build the low-water interrupt; otherwise irq_o is tied low.
module mmio_keys_queued #(
    parameter int KEY_BITS    = 80,
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_FRAMES = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [5:0]          addr_i,
    input  logic                write_i,
    input  logic                read_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    output logic                read_valid_o,
    input  logic                frame_i,
    output logic [KEY_BITS-1:0] keys_o,
    output logic                fifo_full_o,
    output logic                irq_o
);
    localparam int NW = (KEY_BITS + 31) / 32;
    localparam int MW = NW * 32;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [5:0] ADDR_EVENT  = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h21;
    localparam logic [5:0] ADDR_CTRL   = 6'h22;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   keys_q, keys_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            enable_q, enable_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [31:0]     data_q, data_d;
    logic            rvalid_q, rvalid_d;
`ifdef MMIO_KEYS_IRQ_EN
    logic            irq_en_q, irq_en_d;
    logic            irq_q, irq_d;
`endif

    logic            fifo_empty, fifo_full;
    logic            push_req, push_ok, pop;
    logic [7:0]      head;
    logic            head_valid;
    logic [7:0]      hold_eff;
    logic            busy;
    logic            irq_bit;
    logic [31:0]     status_word, ctrl_word, read_word;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = (state_q == APPLY);
    assign push_req   = write_i && (addr_i == ADDR_EVENT);
    // A full FIFO still accepts a push in the cycle the engine pops.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_valid = ({25'd0, head[6:0]} < 32'(KEY_BITS));
    assign hold_eff   = (hold_q == 8'd0) ? 8'd1 : hold_q;
    assign busy       = (state_q != IDLE);

`ifdef MMIO_KEYS_IRQ_EN
    assign irq_bit = irq_en_q;
    assign irq_o   = irq_q;
`else
    assign irq_bit = 1'b0;
    assign irq_o   = 1'b0;
`endif

    assign status_word = {14'd0, busy, ovf_q, 6'd0, fifo_full, fifo_empty, 1'b0, 7'(count_q)};
    assign ctrl_word   = {16'd0, hold_q, 6'd0, irq_bit, enable_q};

    always_comb begin
        keys_d = keys_q;
        for (int w = 0; w < NW; w++) begin
            if (write_i && (addr_i == 6'(w))) begin
                keys_d[32*w +: 32] = data_i;
            end
        end
        // The engine's bit overrides a same-cycle direct write to its word.
        if (pop && head_valid) begin
            keys_d[head[6:0]] = ~head[7];
        end
        for (int i = KEY_BITS; i < MW; i++) begin
            keys_d[i] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        if (write_i && (addr_i == ADDR_STATUS) && data_i[16]) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        enable_d = enable_q;
        hold_d   = hold_q;
`ifdef MMIO_KEYS_IRQ_EN
        irq_en_d = irq_en_q;
        irq_d    = irq_en_q && (count_q <= CW'(FIFO_DEPTH / 2)) && !ovf_q;
`endif
        if (write_i && (addr_i == ADDR_CTRL)) begin
            enable_d = data_i[0];
            hold_d   = data_i[15:8];
`ifdef MMIO_KEYS_IRQ_EN
            irq_en_d = data_i[1];
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable_q && !fifo_empty) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (head_valid) begin
                    state_d    = HOLD;
                    hold_cnt_d = hold_eff;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (frame_i) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                    if (hold_cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_word = 32'hFFFF_FFFF;
        for (int w = 0; w < NW; w++) begin
            if (addr_i == 6'(w)) begin
                read_word = keys_q[32*w +: 32];
            end
        end
        if (addr_i == ADDR_STATUS) begin
            read_word = status_word;
        end
        if (addr_i == ADDR_CTRL) begin
            read_word = ctrl_word;
        end
        data_d   = read_i ? read_word : data_q;
        rvalid_d = read_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            keys_q     <= '1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= 1'b1;
            hold_q     <= 8'(HOLD_FRAMES);
            hold_cnt_q <= 8'd0;
            data_q     <= 32'd0;
            rvalid_q   <= 1'b0;
`ifdef MMIO_KEYS_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            keys_q     <= keys_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            data_q     <= data_d;
            rvalid_q   <= rvalid_d;
`ifdef MMIO_KEYS_IRQ_EN
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
`endif
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {data_i[15], data_i[6:0]};
        end
    end

    assign keys_o       = keys_q[KEY_BITS-1:0];
    assign data_o       = data_q;
    assign read_valid_o = rvalid_q;
    assign fifo_full_o  = fifo_full;
endmodule

// File: tb/tb_mmio_keys_queued.sv
// tb_mmio_keys_queued: scenario tasks for mmio_keys_queued; read results are
// scored against expected words queued at the moment each read is issued.
module tb_mmio_keys_queued;
    localparam int KEY_BITS = 80;
    localparam logic [5:0] A_EVENT  = 6'h20;
    localparam logic [5:0] A_STATUS = 6'h21;
    localparam logic [5:0] A_CTRL   = 6'h22;
    localparam logic [KEY_BITS-1:0] ALL_UP = {KEY_BITS{1'b1}};

    logic                clk_i = 1'b0;
    logic                reset_n_i = 1'b0;
    logic [5:0]          addr_i = 6'd0;
    logic                write_i = 1'b0;
    logic                read_i = 1'b0;
    logic [31:0]         data_i = 32'd0;
    logic [31:0]         data_o;
    logic                read_valid_o;
    logic                frame_i = 1'b0;
    logic [KEY_BITS-1:0] keys_o;
    logic                fifo_full_o;
    logic                irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    mmio_keys_queued #(
        .KEY_BITS(KEY_BITS),
        .FIFO_DEPTH(16),
        .HOLD_FRAMES(2)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .addr_i(addr_i),
        .write_i(write_i),
        .read_i(read_i),
        .data_i(data_i),
        .data_o(data_o),
        .read_valid_o(read_valid_o),
        .frame_i(frame_i),
        .keys_o(keys_o),
        .fifo_full_o(fifo_full_o),
        .irq_o(irq_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        addr_i  = a;
        data_i  = d;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic v);
        addr_i = a;
        read_i = 1'b1;
        tick();
        read_i = 1'b0;
        d = data_o;
        v = read_valid_o;
    endtask

    // Pulses frames until STATUS shows empty and idle, or the budget runs out.
    task automatic drain(output logic [31:0] last);
        logic v;
        last = 32'd0;
        frame_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus_read(A_STATUS, last, v);
            if (last == 32'h0000_0100) break;
        end
        frame_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0]  ra [5];
        logic [31:0] re [5];
        logic [31:0] got, exp;
        logic v;
        ra = '{6'd0, 6'd1, 6'd2, A_STATUS, A_CTRL};
        re = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0201};
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL reset_keys: got %h expected %h", keys_o, ALL_UP); end
        checks++;
        if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", data_o); end
        checks++;
        if ({read_valid_o, fifo_full_o, irq_o} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {read_valid_o, fifo_full_o, irq_o});
        end
        reset_n_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(re[i]);
            bus_read(ra[i], got, v);
            exp = sb_q.pop_front();
            checks++;
            if (v !== 1'b1) begin errors++; $display("[TB] FAIL reset_rvalid[%0d]: got %b expected 1", i, v); end
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL reset_read[%0d]: got %h expected %h", i, got, exp); end
            tick();
            checks++;
            if (read_valid_o !== 1'b0 || data_o !== exp) begin
                errors++; $display("[TB] FAIL reset_pulse[%0d]: got %b/%h expected 0/%h", i, read_valid_o, data_o, exp);
            end
        end
    endtask

    task automatic test_matrix();
        logic [5:0]  ra [4];
        logic [31:0] re [4];
        logic [31:0] got, exp;
        logic v;
        ra = '{6'd0, 6'd1, 6'd2, 6'h30};
        re = '{32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, 32'hFFFF_FFFF};
        bus_write(6'd1, 32'h1234_5678);
        checks++;
        if (keys_o[63:32] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL word1_keys: got %h expected 12345678", keys_o[63:32]); end
        bus_write(6'd2, 32'h0000_0000);
        checks++;
        if (keys_o[79:64] !== 16'h0000) begin errors++; $display("[TB] FAIL word2_keys: got %h expected 0000", keys_o[79:64]); end
        bus_write(6'd0, 32'hA5A5_0F0F);
        bus_write(6'h30, 32'h0000_0000);
        checks++;
        if (keys_o !== {16'h0000, 32'h1234_5678, 32'hA5A5_0F0F}) begin
            errors++; $display("[TB] FAIL unmapped_write: got %h expected 000012345678a5a50f0f", keys_o);
        end
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(re[i]);
            bus_read(ra[i], got, v);
            exp = sb_q.pop_front();
            checks++;
            if (v !== 1'b1 || got !== exp) begin
                errors++; $display("[TB] FAIL matrix_read[%0d]: got %b/%h expected 1/%h", i, v, got, exp);
            end
        end
        for (int w = 0; w < 3; w++) bus_write(6'(w), 32'hFFFF_FFFF);
        checks++;
        if (keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL matrix_restore: got %h expected %h", keys_o, ALL_UP); end
    endtask

    task automatic test_event_pacing();
        logic [31:0] got;
        bus_write(A_CTRL, 32'h0000_0201);
        bus_write(A_EVENT, 32'h0000_8005);
        checks++;
        if (keys_o[5] !== 1'b1) begin errors++; $display("[TB] FAIL press_early1: got %b expected 1", keys_o[5]); end
        bus_write(A_EVENT, 32'h0000_0005);
        checks++;
        if (keys_o[5] !== 1'b1) begin errors++; $display("[TB] FAIL press_early2: got %b expected 1", keys_o[5]); end
        tick();
        checks++;
        if (keys_o !== (ALL_UP & ~(80'd1 << 5))) begin errors++; $display("[TB] FAIL press_applied: got %h", keys_o); end
        repeat (5) tick();
        frame_i = 1'b1; tick(); frame_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (keys_o[5] !== 1'b0) begin errors++; $display("[TB] FAIL hold_one_frame: got %b expected 0", keys_o[5]); end
        frame_i = 1'b1; tick(); frame_i = 1'b0;
        checks++;
        if (keys_o[5] !== 1'b0) begin errors++; $display("[TB] FAIL release_t1: got %b expected 0", keys_o[5]); end
        tick();
        checks++;
        if (keys_o[5] !== 1'b0) begin errors++; $display("[TB] FAIL release_t2: got %b expected 0", keys_o[5]); end
        tick();
        checks++;
        if (keys_o[5] !== 1'b1) begin errors++; $display("[TB] FAIL release_t3: got %b expected 1", keys_o[5]); end
        drain(got);
        checks++;
        if (got !== 32'h0000_0100) begin errors++; $display("[TB] FAIL pacing_drain: got %h expected 00000100", got); end
    endtask

    task automatic test_overflow();
        logic [31:0] re [3];
        logic [31:0] got, exp;
        logic v;
        re = '{32'h0001_0210, 32'h0000_0210, 32'h0002_0210};
        bus_write(A_CTRL, 32'h0000_0200);
        for (int i = 0; i < 17; i++) bus_write(A_EVENT, 32'h0000_800A);
        checks++;
        if (fifo_full_o !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", fifo_full_o); end
        sb_q.push_back(re[0]);
        bus_read(A_STATUS, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== exp) begin errors++; $display("[TB] FAIL ovf_status: got %b/%h expected 1/%h", v, got, exp); end
        bus_write(A_STATUS, 32'h0001_0000);
        sb_q.push_back(re[1]);
        bus_read(A_STATUS, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected %h", got, exp); end
        // Enable, then push exactly in the cycle the engine pops from the full FIFO.
        bus_write(A_CTRL, 32'h0000_0101);
        tick();
        bus_write(A_EVENT, 32'h0000_000A);
        sb_q.push_back(re[2]);
        bus_read(A_STATUS, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL push_on_pop: got %h expected %h", got, exp); end
        drain(got);
        checks++;
        if (got !== 32'h0000_0100) begin errors++; $display("[TB] FAIL ovf_drain: got %h expected 00000100", got); end
        checks++;
        if (keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL ovf_final_keys: got %h expected %h", keys_o, ALL_UP); end
    endtask

    task automatic test_discard();
        logic [31:0] got;
        logic v;
        int n;
        bus_write(A_CTRL, 32'h0000_0201);
        bus_write(A_EVENT, 32'h0000_8064);
        n = 0;
        got = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bus_read(A_STATUS, got, v);
            n++;
            if (got == 32'h0000_0100) break;
        end
        checks++;
        if (got !== 32'h0000_0100 || n < 2) begin errors++; $display("[TB] FAIL discard_idle: got %h after %0d reads expected 00000100", got, n); end
        checks++;
        if (keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL discard_keys: got %h expected %h", keys_o, ALL_UP); end
        bus_write(A_EVENT, 32'h0000_804F);
        tick();
        tick();
        checks++;
        if (keys_o !== (ALL_UP & ~(80'd1 << 79))) begin errors++; $display("[TB] FAIL last_key_press: got %h", keys_o); end
        bus_write(A_EVENT, 32'h0000_004F);
        drain(got);
        checks++;
        if (got !== 32'h0000_0100 || keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL last_key_release: got %h/%h", got, keys_o); end
    endtask

    task automatic test_write_collision();
        logic [31:0] got;
        bus_write(6'd0, 32'hFFFF_FFDF);
        bus_write(A_EVENT, 32'h0000_0005);
        tick();
        bus_write(6'd0, 32'h0000_0000);
        checks++;
        if (keys_o[31:0] !== 32'h0000_0020) begin errors++; $display("[TB] FAIL collision_word: got %h expected 00000020", keys_o[31:0]); end
        drain(got);
        bus_write(6'd0, 32'hFFFF_FFFF);
        checks++;
        if (got !== 32'h0000_0100 || keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL collision_restore: got %h/%h", got, keys_o); end
    endtask

    task automatic test_irq();
        logic [31:0] got, exp;
        logic v;
`ifdef MMIO_KEYS_IRQ_EN
        bus_write(A_CTRL, 32'h0000_0202);
        tick();
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL irq_empty: got %b expected 1", irq_o); end
        for (int i = 0; i < 9; i++) bus_write(A_EVENT, 32'h0000_000A);
        tick();
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_nine: got %b expected 0", irq_o); end
        sb_q.push_back(32'h0000_0202);
        bus_read(A_CTRL, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL irq_ctrl: got %h expected %h", got, exp); end
        bus_write(A_CTRL, 32'h0000_0203);
        for (int i = 0; i < 10; i++) begin
            if (irq_o === 1'b1) break;
            tick();
        end
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL irq_eight: got %b expected 1", irq_o); end
        sb_q.push_back(32'h0002_0208);
        bus_read(A_STATUS, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL irq_status: got %h expected %h", got, exp); end
        drain(got);
`else
        bus_write(A_CTRL, 32'h0000_0203);
        sb_q.push_back(32'h0000_0201);
        bus_read(A_CTRL, got, v);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL irq_ctrl_bit: got %h expected %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_tied[%0d]: got %b expected 0", i, irq_o); end
        end
        drain(got);
`endif
        checks++;
        if (got !== 32'h0000_0100) begin errors++; $display("[TB] FAIL irq_drain: got %h expected 00000100", got); end
    endtask

    task automatic test_reset_mid_hold();
        logic [31:0] re [2];
        logic [31:0] got, exp;
        logic v;
        re = '{32'h0000_0100, 32'h0000_0201};
        bus_write(A_CTRL, 32'h0000_0201);
        bus_write(A_EVENT, 32'h0000_8005);
        bus_write(A_EVENT, 32'h0000_8006);
        bus_write(A_EVENT, 32'h0000_8007);
        checks++;
        if (keys_o[5] !== 1'b0) begin errors++; $display("[TB] FAIL midhold_press: got %b expected 0", keys_o[5]); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (keys_o !== ALL_UP || data_o !== 32'd0 || fifo_full_o !== 1'b0) begin
            errors++; $display("[TB] FAIL midhold_async: got %h/%h/%b", keys_o, data_o, fifo_full_o);
        end
        reset_n_i = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(re[i]);
            bus_read(i == 0 ? A_STATUS : A_CTRL, got, v);
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL midhold_read[%0d]: got %h expected %h", i, got, exp); end
        end
        repeat (4) tick();
        checks++;
        if (keys_o !== ALL_UP) begin errors++; $display("[TB] FAIL midhold_keys: got %h expected %h", keys_o, ALL_UP); end
    endtask

    initial begin
        test_reset();
        test_matrix();
        test_event_pacing();
        test_overflow();
        test_discard();
        test_write_collision();
        test_irq();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
